// File: rtl/mul_err_pkg.sv
// Shared state encoding, operand/product widths and default accumulator
// widths for the approximate-multiplier error monitor.
package mul_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int DEF_SUM_W = 32;
  localparam int DEF_CNT_W = 17;

  // One extra bit keeps the sign of approx - exact before taking the magnitude.
  function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                 input logic [PROD_W-1:0] y);
    logic [PROD_W:0] diff;
    logic [PROD_W:0] neg;
    diff = {1'b0, x} - {1'b0, y};
    neg  = {(PROD_W+1){1'b0}} - diff;
    return diff[PROD_W] ? neg[PROD_W-1:0] : diff[PROD_W-1:0];
  endfunction

endpackage

// File: rtl/mul_error_monitor_ed_pipe.sv
// Two-stage pipe: stage 1 registers the exact product next to the approximate
// one, stage 2 registers their absolute difference (error distance).
module ed_pipe
  import mul_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] approx_p,
  output logic              s1_valid,
  output logic              out_valid,
  output logic [PROD_W-1:0] ed
);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0] exact_q, exact_d;
  logic [PROD_W-1:0] approx_q, approx_d;
  logic [PROD_W-1:0] ed_q, ed_d;

  always_comb begin
    s1_valid_d = in_valid;
    exact_d    = exact_q;
    approx_d   = approx_q;
    s2_valid_d = s1_valid_q;
    ed_d       = ed_q;
    if (in_valid) begin
      exact_d  = PROD_W'(a) * PROD_W'(b);
      approx_d = approx_p;
    end
    if (s1_valid_q) begin
      ed_d = abs_diff(approx_q, exact_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      exact_q    <= '0;
      approx_q   <= '0;
      ed_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      exact_q    <= exact_d;
      approx_q   <= approx_d;
      ed_q       <= ed_d;
    end
  end

  assign s1_valid  = s1_valid_q;
  assign out_valid = s2_valid_q;
  assign ed        = ed_q;

endmodule

// File: rtl/mul_error_monitor.sv
// Streaming error-statistics engine: counts accepted samples, runs them through
// ed_pipe and accumulates ED sum, ED max, mismatch count and sample count.
module mul_error_monitor
  import mul_err_pkg::*;
#(
  parameter int N_SAMPLES = 65025,
  parameter int SUM_W     = DEF_SUM_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] approx_p,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  ed_sum,
  output logic [PROD_W-1:0] ed_max,
  output logic [CNT_W-1:0]  num_wrong,
  output logic [CNT_W-1:0]  num_total
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [SUM_W-1:0]  ed_sum_q, ed_sum_d;
  logic [PROD_W-1:0] ed_max_q, ed_max_d;
  logic [CNT_W-1:0]  num_wrong_q, num_wrong_d;
  logic [CNT_W-1:0]  num_total_q, num_total_d;

  logic              accept;
  logic              pipe_s1_valid;
  logic              pipe_out_valid;
  logic [PROD_W-1:0] pipe_ed;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on state and the accept count; the pipe never stalls.
  assign in_ready = (state_q == RUN) && (acc_cnt_q <= LAST_IDX);
  assign accept   = in_valid && in_ready;

  ed_pipe u_ed_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .a         (a),
    .b         (b),
    .approx_p  (approx_p),
    .s1_valid  (pipe_s1_valid),
    .out_valid (pipe_out_valid),
    .ed        (pipe_ed)
  );

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    ed_sum_d    = ed_sum_q;
    ed_max_d    = ed_max_q;
    num_wrong_d = num_wrong_q;
    num_total_d = num_total_q;

    if (pipe_out_valid) begin
      ed_sum_d    = ed_sum_q + SUM_W'(pipe_ed);
      num_total_d = num_total_q + CNT_W'(1);
      if (pipe_ed > ed_max_q) ed_max_d = pipe_ed;
      if (pipe_ed != '0)      num_wrong_d = num_wrong_q + CNT_W'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        // Pipe is empty here, so clearing overrides nothing in flight.
        if (start) begin
          state_d     = RUN;
          acc_cnt_d   = '0;
          ed_sum_d    = '0;
          ed_max_d    = '0;
          num_wrong_d = '0;
          num_total_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_s1_valid && !pipe_out_valid) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_cnt_q   <= '0;
      ed_sum_q    <= '0;
      ed_max_q    <= '0;
      num_wrong_q <= '0;
      num_total_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      ed_sum_q    <= ed_sum_d;
      ed_max_q    <= ed_max_d;
      num_wrong_q <= num_wrong_d;
      num_total_q <= num_total_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign ed_sum    = ed_sum_q;
  assign ed_max    = ed_max_q;
  assign num_wrong = num_wrong_q;
  assign num_total = num_total_q;

endmodule

// File: tb/tb_mul_error_monitor.sv
// Bench for mul_error_monitor: a 4-sample instance against a queue-based
// scoreboard, plus a default-size instance for the full 255x255 sweep.
module tb_mul_error_monitor;

  localparam int N4    = 4;
  localparam int EXP_W = 114;  // {due_cycle[31:0], sum[31:0], max[15:0], wrong[16:0], total[16:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, in_valid4 = 1'b0;
  logic d_start = 1'b0, d_in_valid = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] approx_p = '0;

  logic        in_ready4, busy4, done4;
  logic [31:0] ed_sum4;
  logic [15:0] ed_max4;
  logic [16:0] num_wrong4, num_total4;
  logic        d_in_ready, d_busy, d_done;
  logic [31:0] d_ed_sum;
  logic [15:0] d_ed_max;
  logic [16:0] d_num_wrong, d_num_total;

  int checks = 0, errors = 0;
  logic [31:0] cyc = '0;
  logic [31:0] last_acc = '0;
  int m_sum, m_max, m_wrong, m_total, m_acc;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] fin_q[$];
  logic done_prev = 1'b0;

  mul_error_monitor #(.N_SAMPLES(N4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .approx_p(approx_p), .busy(busy4), .done(done4),
    .ed_sum(ed_sum4), .ed_max(ed_max4), .num_wrong(num_wrong4), .num_total(num_total4)
  );

  mul_error_monitor dutd (
    .clk(clk), .rst_n(rst_n), .start(d_start), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(a), .b(b), .approx_p(approx_p), .busy(d_busy), .done(d_done),
    .ed_sum(d_ed_sum), .ed_max(d_ed_max), .num_wrong(d_num_wrong), .num_total(d_num_total)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: statistics from the definition of error distance.
  task automatic model_accept(input logic [7:0] sa, input logic [7:0] sb,
                              input logic [15:0] sp, input logic [31:0] due);
    int ed;
    ed = int'(sp) - int'(sa) * int'(sb);
    if (ed < 0) ed = -ed;
    m_sum += ed;
    if (ed > m_max) m_max = ed;
    if (ed != 0) m_wrong++;
    m_total++;
    m_acc++;
    exp_q.push_back({due, 32'(m_sum), 16'(m_max), 17'(m_wrong), 17'(m_total)});
    if (m_acc == N4) fin_q.push_back({due, 32'(m_sum), 16'(m_max), 17'(m_wrong), 17'(m_total)});
  endtask

  // Scoreboard monitor: running stats at their due cycle, final stats on done.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    done_prev <= done4;
    if (exp_q.size() > 0 && exp_q[0][113:82] == cyc) begin
      e = exp_q.pop_front();
      check("run_sum",   64'(ed_sum4),    64'(e[81:50]));
      check("run_max",   64'(ed_max4),    64'(e[49:34]));
      check("run_wrong", 64'(num_wrong4), 64'(e[33:17]));
      check("run_total", 64'(num_total4), 64'(e[16:0]));
    end
    if (done4 && !done_prev) begin
      if (fin_q.size() == 0) begin
        check("done_unexpected", 64'd1, 64'd0);
      end else begin
        e = fin_q.pop_front();
        check("final_sum",   64'(ed_sum4),    64'(e[81:50]));
        check("final_max",   64'(ed_max4),    64'(e[49:34]));
        check("final_wrong", 64'(num_wrong4), 64'(e[33:17]));
        check("final_total", 64'(num_total4), 64'(e[16:0]));
      end
    end
  end

  // Driver tasks
  task automatic start_run();
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    m_sum = 0; m_max = 0; m_wrong = 0; m_total = 0; m_acc = 0;
    check("clear_sum",   64'(ed_sum4),    64'd0);
    check("clear_max",   64'(ed_max4),    64'd0);
    check("clear_wrong", 64'(num_wrong4), 64'd0);
    check("clear_total", 64'(num_total4), 64'd0);
    check("start_busy",  64'(busy4),      64'd1);
    check("start_done",  64'(done4),      64'd0);
    check("start_ready", 64'(in_ready4),  64'd1);
  endtask

  // Must be entered just after a rising edge.
  task automatic send4(input logic [7:0] sa, input logic [7:0] sb, input logic [15:0] sp,
                       input int gap, input bit with_start);
    int n;
    in_valid4 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    a = sa; b = sb; approx_p = sp; in_valid4 = 1'b1; start4 = with_start;
    n = 0;
    @(negedge clk);
    while (!in_ready4 && n < 20) begin @(negedge clk); n++; end
    if (!in_ready4) begin
      check("accept_timeout", 64'(in_ready4), 64'd1);
      in_valid4 = 1'b0; start4 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0; start4 = 1'b0;
    last_acc = cyc;
    model_accept(sa, sb, sp, cyc + 32'd2);
  endtask

  task automatic finish4();
    int n;
    @(negedge clk);
    check("in_ready_drop", 64'(in_ready4), 64'd0);
    check("busy_drain",    64'(busy4),     64'd1);
    n = 0;
    while (!done4 && n < 12) begin @(negedge clk); n++; end
    check("done_latency", 64'(cyc - last_acc), 64'd3);
  endtask

  task automatic toggle_inputs(input int cycles);
    repeat (cycles) begin
      in_valid4 = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      approx_p = 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
  endtask

  initial begin
    logic [7:0]  sa, sb;
    logic [15:0] sp, ex;
    int sel;

    #12;
    check("rst_ready", 64'(in_ready4), 64'd0);
    check("rst_busy",  64'(busy4),     64'd0);
    check("rst_done",  64'(done4),     64'd0);
    check("rst_total", 64'(num_total4), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    toggle_inputs(6);
    check("idle_total", 64'(num_total4), 64'd0);
    check("idle_sum",   64'(ed_sum4),    64'd0);
    check("idle_ready", 64'(in_ready4),  64'd0);
    check("idle_busy",  64'(busy4),      64'd0);

    start_run();
    for (int i = 0; i < 4; i++) send4(8'd3, 8'd5, 16'd15, 0, 1'b0);
    finish4();

    toggle_inputs(5);
    check("hold_total", 64'(num_total4), 64'(m_total));
    check("hold_sum",   64'(ed_sum4),    64'(m_sum));
    check("hold_done",  64'(done4),      64'd1);
    check("hold_ready", 64'(in_ready4),  64'd0);

    start_run();
    send4(8'd10,  8'd10,  16'd90,    1, 1'b0);
    send4(8'd255, 8'd255, 16'd65000, 0, 1'b0);
    send4(8'd1,   8'd1,   16'd1,     2, 1'b0);
    send4(8'd7,   8'd9,   16'd60,    0, 1'b0);
    finish4();

    start_run();
    for (int i = 0; i < 4; i++) send4(8'd0, 8'd0, 16'd65535, i, 1'b0);
    finish4();

    for (int r = 0; r < 3; r++) begin
      start_run();
      for (int i = 0; i < 4; i++) begin
        sa = 8'($urandom_range(0, 255));
        sb = 8'($urandom_range(0, 255));
        ex = 16'(sa) * 16'(sb);
        sel = $urandom_range(0, 2);
        sp = (sel == 0) ? ex : (sel == 1) ? 16'($urandom_range(0, 65535))
                                          : ex ^ 16'(1 << $urandom_range(0, 15));
        send4(sa, sb, sp, $urandom_range(0, 3), (r == 0 && i == 3) || (r == 1 && i == 1));
      end
      finish4();
    end

    start_run();
    for (int i = 0; i < 3; i++) send4(8'd2, 8'd3, 16'd7, 0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset_total", 64'(num_total4), 64'd2);
    #2 rst_n = 1'b0;
    exp_q.delete();
    fin_q.delete();
    #1;
    check("async_rst_sum",   64'(ed_sum4),    64'd0);
    check("async_rst_max",   64'(ed_max4),    64'd0);
    check("async_rst_wrong", 64'(num_wrong4), 64'd0);
    check("async_rst_total", 64'(num_total4), 64'd0);
    check("async_rst_busy",  64'(busy4),      64'd0);
    check("async_rst_ready", 64'(in_ready4),  64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    toggle_inputs(4);
    check("post_rst_ready", 64'(in_ready4),  64'd0);
    check("post_rst_busy",  64'(busy4),      64'd0);
    check("post_rst_total", 64'(num_total4), 64'd0);

    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    check("sweep_busy", 64'(d_busy), 64'd1);
    for (int i = 1; i <= 255; i++) begin
      for (int j = 1; j <= 255; j++) begin
        a = 8'(i); b = 8'(j); approx_p = 16'(i * j); d_in_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    d_in_valid = 1'b0;
    last_acc = cyc;
    @(negedge clk);
    check("sweep_ready_drop", 64'(d_in_ready), 64'd0);
    for (int n = 0; n < 12 && !d_done; n++) @(negedge clk);
    check("sweep_done_latency", 64'(cyc - last_acc), 64'd3);
    check("sweep_total", 64'(d_num_total), 64'd65025);
    check("sweep_wrong", 64'(d_num_wrong), 64'd0);
    check("sweep_sum",   64'(d_ed_sum),    64'd0);
    check("sweep_max",   64'(d_ed_max),    64'd0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("fin_q_drained", 64'(fin_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
